// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the decode/writeback side (master) and the
// multi-cycle multiply/divide sequencer (slave).
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_rs1;
   logic [XLEN-1:0] req_rs2;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_data;

   modport master (
      output req_valid, req_funct3, req_rs1, req_rs2, resp_ready,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_funct3, req_rs1, req_rs2, resp_ready,
      output req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide that borrows the core ALU: shift-add for MUL*,
// restoring division for DIV*/REM*, with sign fix-up on magnitudes.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a request, req_ready high
// PREP     | take operand magnitudes, record negate flag, catch divide-by-zero
// MUL_IT   | one shift-add step per cycle on the borrowed ALU (add)
// DIV_IT   | one restoring-division step per cycle on the borrowed ALU (sub)
// FIXUP    | negate and select the result word into resp_data
// DONE     | resp_valid held until writeback accepts
module muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int ITERS = XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   muldiv_seq_if.slave     bus,
   output logic            busy,
   output logic            alu_en,
   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] alu_in1,
   output logic [XLEN-1:0] alu_in2,
   input  logic [XLEN-1:0] alu_result
);

   localparam int CW = $clog2(ITERS);
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;

   typedef enum logic [2:0] {
      S_IDLE, S_PREP, S_MUL_IT, S_DIV_IT, S_FIXUP, S_DONE
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      funct3_q;
   logic [XLEN-1:0] rs1_q, rs2_q;
   logic [XLEN-1:0] hi_q, lo_q, opb_q;
   logic            neg_q;
   logic [XLEN-1:0] resp_data_q;
   logic            resp_valid_q, busy_q, req_ready_q, alu_en_q;
   logic [3:0]      alu_op_q;

   logic [XLEN-1:0]   sh, abs1, abs2;
   logic              take, carry, sgn1, sgn2, sign1, sign2, neg_d, div0;
   logic [XLEN-1:0]   mul_hi_d, mul_lo_d, div_rem_d, div_quo_d, result_d;
   logic [2*XLEN-1:0] prod, prod_n;

   // hi/lo/opb are shared: acc_hi/acc_lo/mcand when multiplying, rem/quo/dvs when dividing
   always_comb begin
      sh        = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
      take      = hi_q[XLEN-1] | (sh >= opb_q);
      carry     = (alu_result < hi_q);
      mul_hi_d  = {carry, alu_result[XLEN-1:1]};
      mul_lo_d  = {alu_result[0], lo_q[XLEN-1:1]};
      div_rem_d = take ? alu_result : sh;
      div_quo_d = {lo_q[XLEN-2:0], take};

      sgn1 = 1'b0;
      sgn2 = 1'b0;
      case (funct3_q)
         3'b000, 3'b001, 3'b100, 3'b110: begin sgn1 = 1'b1; sgn2 = 1'b1; end
         3'b010:                         sgn1 = 1'b1;
         default: ;
      endcase
      sign1 = sgn1 & rs1_q[XLEN-1];
      sign2 = sgn2 & rs2_q[XLEN-1];
      abs1  = sign1 ? -rs1_q : rs1_q;
      abs2  = sign2 ? -rs2_q : rs2_q;
      neg_d = (funct3_q[2] & funct3_q[1]) ? sign1 : (sign1 ^ sign2);
      div0  = funct3_q[2] & (rs2_q == '0);

      prod   = {hi_q, lo_q};
      prod_n = neg_q ? -prod : prod;
      case (funct3_q)
         3'b000:                 result_d = prod_n[XLEN-1:0];
         3'b001, 3'b010, 3'b011: result_d = prod_n[2*XLEN-1:XLEN];
         3'b100, 3'b101:         result_d = neg_q ? -lo_q : lo_q;
         default:                result_d = neg_q ? -hi_q : hi_q;
      endcase
   end

   always_comb begin
      alu_in1 = '0;
      alu_in2 = '0;
      if (state_q == S_MUL_IT) begin
         alu_in1 = hi_q;
         alu_in2 = lo_q[0] ? opb_q : '0;
      end else if (state_q == S_DIV_IT) begin
         alu_in1 = sh;
         alu_in2 = opb_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         funct3_q     <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         opb_q        <= '0;
         neg_q        <= 1'b0;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         req_ready_q  <= 1'b1;
         alu_en_q     <= 1'b0;
         alu_op_q     <= ALU_ADD;
      end else if (flush) begin
         // abort wins over both handshakes; resp_data keeps its last value
         state_q      <= S_IDLE;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         req_ready_q  <= 1'b1;
         alu_en_q     <= 1'b0;
         alu_op_q     <= ALU_ADD;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  funct3_q    <= bus.req_funct3;
                  rs1_q       <= bus.req_rs1;
                  rs2_q       <= bus.req_rs2;
                  state_q     <= S_PREP;
                  busy_q      <= 1'b1;
                  req_ready_q <= 1'b0;
               end
            end
            S_PREP: begin
               cnt_q <= '0;
               neg_q <= neg_d;
               hi_q  <= '0;
               if (div0) begin
                  resp_data_q  <= funct3_q[1] ? rs1_q : '1;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_DONE;
               end else if (funct3_q[2]) begin
                  lo_q     <= abs1;
                  opb_q    <= abs2;
                  alu_en_q <= 1'b1;
                  alu_op_q <= ALU_SUB;
                  state_q  <= S_DIV_IT;
               end else begin
                  lo_q     <= abs2;
                  opb_q    <= abs1;
                  alu_en_q <= 1'b1;
                  alu_op_q <= ALU_ADD;
                  state_q  <= S_MUL_IT;
               end
            end
            S_MUL_IT, S_DIV_IT: begin
               hi_q  <= (state_q == S_MUL_IT) ? mul_hi_d : div_rem_d;
               lo_q  <= (state_q == S_MUL_IT) ? mul_lo_d : div_quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(ITERS - 1)) begin
                  alu_en_q <= 1'b0;
                  alu_op_q <= ALU_ADD;
                  state_q  <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               resp_data_q  <= result_d;
               resp_valid_q <= 1'b1;
               state_q      <= S_DONE;
            end
            S_DONE: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign busy           = busy_q;
   assign alu_en         = alu_en_q;
   assign alu_op         = alu_op_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: models the core ALU, predicts every result with
// plain 64-bit arithmetic, and checks latency, handshakes and abort behaviour.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        busy, alu_en;
   logic [3:0]  alu_op;
   logic [31:0] alu_in1, alu_in2, alu_result;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [2:0]  cur_f3 = 3'b000;

   always #5 clk = ~clk;

   muldiv_seq_if bus ();

   assign alu_result = (alu_op == 4'b0001) ? alu_in1 - alu_in2 : alu_in1 + alu_in2;

   muldiv_seq dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .bus        (bus),
      .busy       (busy),
      .alu_en     (alu_en),
      .alu_op     (alu_op),
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .alu_result (alu_result)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFFFFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   // cycle-by-cycle compare against the queued predictions
   always @(negedge clk) begin
      if (!reset) begin
         chk("busy_vs_ready", 64'(busy), 64'(!bus.req_ready));
         if (alu_en) begin
            chk("alu_op_iter", 64'(alu_op), cur_f3[2] ? 64'd1 : 64'd0);
         end else begin
            chk("alu_op_idle", 64'(alu_op), 64'd0);
            chk("alu_in1_idle", 64'(alu_in1), 64'd0);
            chk("alu_in2_idle", 64'(alu_in2), 64'd0);
         end
         if (bus.resp_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_resp actual=%0h required=none", bus.resp_data);
            end else begin
               chk("resp_data", 64'(bus.resp_data), 64'(exp_q[0]));
               if (bus.resp_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // called at posedge+1; returns at posedge+1 after the response handshake
   task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit,
                         input int exp_edges, input int hold);
      int          edges;
      int          alu_cnt;
      logic [31:0] first;
      chk({nm, "_model"}, 64'(model(f3, a, b)), 64'(lit));
      bus.req_valid  = 1'b1;
      bus.req_funct3 = f3;
      bus.req_rs1    = a;
      bus.req_rs2    = b;
      bus.resp_ready = (hold == 0);
      @(negedge clk);
      chk({nm, "_req_ready"}, 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      cur_f3 = f3;
      exp_q.push_back(model(f3, a, b));
      #1 bus.req_valid = 1'b0;
      edges   = 0;
      alu_cnt = 0;
      while (!bus.resp_valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
         if (alu_en) alu_cnt++;
      end
      chk({nm, "_latency"}, 64'(edges), 64'(exp_edges));
      if (exp_edges > 1) chk({nm, "_alu_cycles"}, 64'(alu_cnt), 64'd32);
      first = bus.resp_data;
      chk(nm, 64'(first), 64'(lit));
      if (hold > 0) begin
         repeat (hold) begin
            @(posedge clk);
            #1;
            chk({nm, "_hold_valid"}, 64'(bus.resp_valid), 64'd1);
            chk({nm, "_hold_data"}, 64'(bus.resp_data), 64'(first));
         end
         bus.resp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk({nm, "_valid_drop"}, 64'(bus.resp_valid), 64'd0);
      chk({nm, "_back_idle"}, 64'(bus.req_ready), 64'd1);
   endtask

   task automatic abort_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input int at_edge, input bit use_reset);
      bus.req_valid  = 1'b1;
      bus.req_funct3 = f3;
      bus.req_rs1    = a;
      bus.req_rs2    = b;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      cur_f3 = f3;
      #1 bus.req_valid = 1'b0;
      repeat (at_edge) @(posedge clk);
      #1;
      chk({nm, "_pre_busy"}, 64'(busy), 64'd1);
      chk({nm, "_pre_alu_en"}, 64'(alu_en), use_reset ? 64'd0 : 64'd1);
      if (use_reset) reset = 1'b1;
      else flush = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      flush = 1'b0;
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
      chk({nm, "_req_ready"}, 64'(bus.req_ready), 64'd1);
      chk({nm, "_alu_en"}, 64'(alu_en), 64'd0);
      if (use_reset) chk({nm, "_resp_data"}, 64'(bus.resp_data), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk({nm, "_quiet"}, 64'(bus.resp_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      flush          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_rs1    = 32'd0;
      bus.req_rs2    = 32'd0;
      bus.resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
      chk("rst_alu_en", 64'(alu_en), 64'd0);
      chk("rst_alu_op", 64'(alu_op), 64'd0);
      chk("rst_alu_in1", 64'(alu_in1), 64'd0);
      chk("rst_alu_in2", 64'(alu_in2), 64'd0);

      run_op("mulhu_ff",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
      run_op("mul_ff",     3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34, 0);
      run_op("mulh_m7x3",  3'd1, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 34, 0);
      run_op("mul_m7x3",   3'd0, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFEB, 34, 0);
      run_op("mulhsu_ff",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0);
      run_op("div_m20_6",  3'd4, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 34, 0);
      run_op("rem_m20_6",  3'd6, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 34, 0);
      run_op("divu_100_7", 3'd5, 32'd100,      32'd7,        32'd14,       34, 10);
      run_op("remu_100_7", 3'd7, 32'd100,      32'd7,        32'd2,        34, 0);
      run_op("divu_5_0",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
      run_op("rem_5_0",    3'd6, 32'd5,        32'd0,        32'd5,        1,  0);
      run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 0);
      run_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34, 0);
      run_op("rem_7_m3",   3'd6, 32'd7,        32'hFFFFFFFD, 32'd1,        34, 0);
      run_op("mulhu_big",  3'd3, 32'h80000000, 32'd4,        32'd2,        34, 0);

      abort_op("flush_it12", 3'd0, 32'd12345, 32'd678, 13, 1'b0);
      run_op("mul_6x7_a",  3'd0, 32'd6, 32'd7, 32'd42, 34, 0);
      abort_op("reset_fixup", 3'd4, 32'd1000, 32'd7, 33, 1'b1);
      run_op("mul_6x7_b",  3'd0, 32'd6, 32'd7, 32'd42, 34, 0);

      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
